// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register (IR + PC+4) with synchronous flush.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered In_Ready.
module pipe_stage_reg #(
    parameter int IR_W = 32,
    parameter int PC_W = 32
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [IR_W-1:0] In_IR,
    input  logic [PC_W-1:0] In_PC4,
    input  logic            Flush,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [IR_W-1:0] Out_IR,
    output logic [PC_W-1:0] Out_PC4
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic            acc, con;

    assign Out_Valid = state_q != EMPTY;
    assign Out_IR    = ir_q;
    assign Out_PC4   = pc4_q;
    assign acc       = In_Valid && In_Ready;
    assign con       = Out_Valid && Out_Ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [IR_W-1:0] sk_ir_q, sk_ir_d;
    logic [PC_W-1:0] sk_pc4_q, sk_pc4_d;
    logic            rdy_q, rdy_d;

    assign In_Ready = rdy_q;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc4_d    = pc4_q;
        sk_ir_d  = sk_ir_q;
        sk_pc4_d = sk_pc4_q;
        if (Flush) begin
            state_d  = EMPTY;
            ir_d     = '0;
            pc4_d    = '0;
            sk_ir_d  = '0;
            sk_pc4_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        ir_d    = In_IR;
                        pc4_d   = In_PC4;
                    end
                end
                ONE: begin
                    if (acc && con) begin
                        ir_d  = In_IR;
                        pc4_d = In_PC4;
                    end else if (acc) begin
                        state_d  = TWO;
                        sk_ir_d  = In_IR;
                        sk_pc4_d = In_PC4;
                    end else if (con) begin
                        state_d = EMPTY;
                        ir_d    = '0;
                        pc4_d   = '0;
                    end
                end
                TWO: begin
                    // In_Ready is low here, so only a consume can move the stage
                    if (con) begin
                        state_d  = ONE;
                        ir_d     = sk_ir_q;
                        pc4_d    = sk_pc4_q;
                        sk_ir_d  = '0;
                        sk_pc4_d = '0;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    ir_d     = '0;
                    pc4_d    = '0;
                    sk_ir_d  = '0;
                    sk_pc4_d = '0;
                end
            endcase
        end
        rdy_d = state_d != TWO;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= EMPTY;
            ir_q     <= '0;
            pc4_q    <= '0;
            sk_ir_q  <= '0;
            sk_pc4_q <= '0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc4_q    <= pc4_d;
            sk_ir_q  <= sk_ir_d;
            sk_pc4_q <= sk_pc4_d;
            rdy_q    <= rdy_d;
        end
    end
`else
    assign In_Ready = !Out_Valid || Out_Ready;

    // Without a skid register an accept always lands in main, replacing or filling it
    always_comb begin
        state_d = Flush ? EMPTY : acc ? ONE : con ? EMPTY : state_q;
        ir_d    = (Flush || (!acc && con)) ? '0 : acc ? In_IR : ir_q;
        pc4_d   = (Flush || (!acc && con)) ? '0 : acc ? In_PC4 : pc4_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
            ir_q    <= '0;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench; reference is an ordered queue bounded at the stage capacity.
module tb_pipe_stage_reg;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [31:0] In_IR = '0;
    logic [31:0] In_PC4 = '0;
    logic        Flush = 1'b0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Out_IR;
    logic [31:0] Out_PC4;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic        acc_ok = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    pipe_stage_reg #(.IR_W(32), .PC_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_IR(In_IR), .In_PC4(In_PC4), .Flush(Flush), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_IR(Out_IR), .Out_PC4(Out_PC4)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side: an instruction accepted at this edge becomes an expected output
    always @(posedge Clk) begin
        if (Reset_n && acc_ok) exp_q.push_back({In_IR, In_PC4});
    end

    // Monitor: compare presented output against the queue head, then retire consumed entries
    always @(negedge Clk) begin
        logic exp_rdy;
        if (!Reset_n) begin
            exp_q.delete();
            acc_ok = 1'b0;
            chk("reset_valid", {31'b0, Out_Valid}, 32'd0);
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            exp_rdy = exp_q.size() < CAP;
`else
            exp_rdy = exp_q.size() == 0 || Out_Ready;
`endif
            chk("out_valid", {31'b0, Out_Valid}, {31'b0, exp_q.size() != 0});
            chk("out_ir", Out_IR, exp_q.size() != 0 ? exp_q[0][63:32] : 32'd0);
            chk("out_pc4", Out_PC4, exp_q.size() != 0 ? exp_q[0][31:0] : 32'd0);
            chk("in_ready", {31'b0, In_Ready}, {31'b0, exp_rdy});
            if (exp_q.size() != 0 && Out_Ready) void'(exp_q.pop_front());
            acc_ok = In_Valid && exp_rdy && !Flush;
            if (Flush) exp_q.delete();
        end
    end

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(posedge Clk);
        #1;
        In_Valid  = v;
        In_IR     = ir;
        In_PC4    = pc;
        Out_Ready = ordy;
        Flush     = fl;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        // streaming
        drive(1, 32'h20010001, 32'h00001004, 1, 0);
        drive(1, 32'h20020002, 32'h00001008, 1, 0);
        drive(1, 32'h20030003, 32'h0000100C, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        // stall then release
        drive(1, 32'h11111111, 32'h00002004, 0, 0);
        drive(1, 32'h22222222, 32'h00002008, 0, 0);
        drive(1, 32'h22222222, 32'h00002008, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        // flush with a full stage and a live input
        drive(1, 32'hAAAA0000, 32'h00003000, 0, 0);
        drive(1, 32'hBBBB0000, 32'h00003004, 0, 0);
        drive(1, 32'hCCCC0000, 32'h00003008, 0, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        // drain after a single accept
        drive(1, 32'h3C01FFFF, 32'h00003004, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        // asynchronous reset mid-cycle while holding an instruction
        drive(1, 32'h8C220004, 32'h00004004, 0, 0);
        drive(0, 0, 0, 0, 0);
        #2;
        chk("pre_reset_ir", Out_IR, 32'h8C220004);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'b0, Out_Valid}, 32'd0);
        chk("async_reset_ir", Out_IR, 32'd0);
        chk("async_reset_pc4", Out_PC4, 32'd0);
        drive(1, 32'hDEAD0000, 32'h1, 1, 1);
        drive(0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        // randomized traffic
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
        @(posedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed IR/PC4 stage latch between any two stages of the pipelined MIPS core. It moves one instruction word plus its PC+4 from an upstream stage to a downstream stage under a valid/ready handshake, with synchronous flush. An optional one-entry skid buffer keeps the ready path registered without losing throughput. When empty, the stage presents a NOP (all-zero IR).

## Interface
- `IR_W`, 32: instruction word width.
- `PC_W`, 32: PC+4 width.
- `Clk`  input  1  clock; all state changes on rising edge.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `In_Valid`  input  1  upstream presents an instruction.
- `In_Ready`  output  1  stage accepts the upstream instruction this cycle.
- `In_IR`  input  IR_W  upstream instruction word.
- `In_PC4`  input  PC_W  upstream PC+4.
- `Flush`  input  1  synchronous kill of all held instructions and of the current input.
- `Out_Valid`  output  1  stage holds a live instruction.
- `Out_Ready`  input  1  downstream consumes the instruction this cycle.
- `Out_IR`  output  IR_W  held instruction word; 0 when `Out_Valid`=0.
- `Out_PC4`  output  PC_W  held PC+4; 0 when `Out_Valid`=0.

## Operation
- Accept: `In_Valid && In_Ready`. Consume: `Out_Valid && Out_Ready`.
- Main register (`Out_*`) plus, with skid enabled, one skid register. Occupancy state is one of EMPTY, ONE or TWO.
- State transitions when `Flush`=0:
  - EMPTY + accept -> ONE; the input loads the main register.
  - ONE + accept + consume -> ONE; the main register takes the input.
  - ONE + accept, no consume -> TWO; the input goes to the skid register.
  - ONE + consume, no accept -> EMPTY; the main register clears to 0.
  - TWO + consume -> ONE; skid moves to main. No accept is possible in TWO.
  - No event -> state and payload unchanged.
- `Flush`=1 overrides all events:
  - Next state is EMPTY.
  - Main and skid payloads clear to 0.
  - The input is discarded even if `In_Valid`=1.
  - The consume handshake in the flush cycle still counts as delivered.
- Payload is never modified while held, so a stalled downstream sees a stable `Out_IR`/`Out_PC4`.
- Ordering is strict FIFO: skid content always leaves after main content.
- No width arithmetic. Payload is copied bit-exact.

## Timing
- Reset (`Reset_n`=0, asynchronous):
  - State becomes EMPTY.
  - `Out_Valid`=0, `Out_IR`=0, `Out_PC4`=0.
  - `In_Ready`=1 with skid enabled.
  - Release is synchronous to `Clk`; first accept is possible on the first rising edge after release.
- Latency: an instruction accepted at edge N appears on `Out_*` immediately after edge N when the stage was EMPTY or being consumed. Otherwise it appears after the edge where the main register drains.
- Throughput: one instruction per cycle while `Out_Ready`=1.
- `In_Ready` with skid: registered, equal to `!(state==TWO)`. It has no combinational path from `Out_Ready`.
- `In_Ready` without skid: `!Out_Valid || Out_Ready`, combinational. State TWO is unreachable.
- `Flush` while `Reset_n`=0 has no effect; reset dominates.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: skid register and state TWO are present, and `In_Ready` is registered as above.
- `PIPE_STAGE_SKID_EN` undefined: no skid register, and `In_Ready` is combinational as above.
- Port list, reset values and all handshake semantics are identical in both builds.

## Test plan
- Reset: drive `Reset_n`=0 mid-cycle with the stage in ONE, `Out_IR`=0x8C220004 -> `Out_Valid`=0 and `Out_IR`=0 immediately, before any clock edge.
- Streaming: `Out_Ready`=1, `In_Valid`=1 with IR 0x20010001, 0x20020002, 0x20030003 on consecutive edges -> same words appear on `Out_IR` one edge later, with no bubbles.
- Stall (skid build): `Out_Ready`=0 while sending 0x11111111 then 0x22222222 -> after the second accept `In_Ready`=0. Raising `Out_Ready` for two cycles delivers 0x11111111 then 0x22222222, and `In_Ready` returns to 1 one edge after the first consume.
- Flush: stage in TWO (0xAAAA0000, 0xBBBB0000), `Flush`=1 with `In_Valid`=1 and IR 0xCCCC0000 -> next edge gives `Out_Valid`=0 and `Out_IR`=0, and 0xCCCC0000 is never output.
- Drain: single accept of 0x3C01FFFF with PC4 0x00003004, then `In_Valid`=0 and `Out_Ready`=1 -> one cycle valid, then `Out_Valid`=0 and `Out_IR`=`Out_PC4`=0.
- Non-skid build: repeat the stall scenario -> `In_Ready` follows `Out_Ready` combinationally while full, and no instruction is lost or duplicated.
